// File: rtl/stride3_monitor.sv
// In-system integrity monitor for the stride-3 up/down counter with load:
// predicts each next count, flags and counts mismatches, and counts complete laps.
module stride3_monitor #(
    parameter int WIDTH  = 3,
    parameter int STRIDE = 3,
    parameter int ERR_W  = 8,
    parameter int LAP_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] count,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             clr_err,
    output logic             locked,
    output logic [WIDTH-1:0] expected,
    output logic             mismatch,
    output logic             sticky_err,
    output logic [ERR_W-1:0] err_cnt,
    output logic             lap_pulse,
    output logic [LAP_W-1:0] lap_cnt
);

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] STEP = WIDTH'(STRIDE);

    state_t           state_r;
    logic [WIDTH-1:0] prev_r;
    logic [WIDTH-1:0] data_q_r;
    logic [WIDTH-1:0] anchor_r;
    logic [WIDTH-1:0] steps_r;
    logic             up_q_r;
    logic             load_q_r;
    logic             dir_q_r;

    logic [WIDTH-1:0] pred_s;
    logic [WIDTH-1:0] steps_inc_s;
    logic             miss_s;
    logic             restart_s;
    logic             wrap_s;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        logic [ERR_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + ERR_W'(1);
        end
        return r;
    endfunction

    // Next-value prediction and lap-tracking decisions for the current cycle
    always_comb begin
        pred_s      = prev_r;
        steps_inc_s = steps_r + WIDTH'(1);
        if (load_q_r) begin
            pred_s = data_q_r;
        end else if (up_q_r) begin
            pred_s = prev_r + STEP;
        end else begin
            pred_s = prev_r - STEP;
        end
        miss_s    = (state_r == LOCKED) && en && (count != pred_s);
        restart_s = miss_s || load_q_r || (up_q_r != dir_q_r);
        wrap_s    = (steps_inc_s == {WIDTH{1'b0}});
    end

    // Monitor FSM, history capture, lap tracking and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= UNLOCKED;
            prev_r     <= {WIDTH{1'b0}};
            data_q_r   <= {WIDTH{1'b0}};
            anchor_r   <= {WIDTH{1'b0}};
            steps_r    <= {WIDTH{1'b0}};
            up_q_r     <= 1'b0;
            load_q_r   <= 1'b0;
            dir_q_r    <= 1'b0;
            locked     <= 1'b0;
            expected   <= {WIDTH{1'b0}};
            mismatch   <= 1'b0;
            sticky_err <= 1'b0;
            err_cnt    <= {ERR_W{1'b0}};
            lap_pulse  <= 1'b0;
            lap_cnt    <= {LAP_W{1'b0}};
        end else begin
            expected  <= pred_s;
            mismatch  <= 1'b0;
            lap_pulse <= 1'b0;

            if (en) begin
                prev_r   <= count;
                up_q_r   <= up;
                load_q_r <= load;
                data_q_r <= data;
            end

            case (state_r)
                UNLOCKED: begin
                    if (en) begin
                        anchor_r <= count;
                        steps_r  <= {WIDTH{1'b0}};
                        dir_q_r  <= up;
                        state_r  <= LOCKED;
                        locked   <= 1'b1;
                    end else begin
                        locked   <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (!en) begin
                        state_r <= UNLOCKED;
                        locked  <= 1'b0;
                    end else begin
                        locked   <= 1'b1;
                        mismatch <= miss_s;
                        // A wrap that misses the anchor is not a lap; start over from here
                        if (restart_s || (wrap_s && (count != anchor_r))) begin
                            anchor_r <= count;
                            steps_r  <= {WIDTH{1'b0}};
                            dir_q_r  <= up;
                        end else if (wrap_s) begin
                            steps_r   <= {WIDTH{1'b0}};
                            lap_pulse <= 1'b1;
                            lap_cnt   <= lap_cnt + LAP_W'(1);
                        end else begin
                            steps_r <= steps_inc_s;
                        end
                    end
                end
                default: begin
                    state_r <= UNLOCKED;
                    locked  <= 1'b0;
                end
            endcase

            if (miss_s) begin
                sticky_err <= 1'b1;
                if (clr_err) begin
                    err_cnt <= ERR_W'(1);
                end else begin
                    err_cnt <= sat_inc(err_cnt);
                end
            end else if (clr_err) begin
                sticky_err <= 1'b0;
                err_cnt    <= {ERR_W{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_stride3_monitor.sv
// Self-checking bench for stride3_monitor: directed scenarios plus randomized
// traffic, compared every cycle against a behavioural model.
module tb_stride3_monitor;

    logic       clk = 1'b0;
    logic       reset, en, up, load, clr_err;
    logic [2:0] count, data, expected;
    logic       locked, mismatch, sticky_err, lap_pulse;
    logic [7:0] err_cnt, lap_cnt;

    stride3_monitor dut (
        .clk(clk), .reset(reset), .en(en), .count(count), .up(up), .load(load),
        .data(data), .clr_err(clr_err), .locked(locked), .expected(expected),
        .mismatch(mismatch), .sticky_err(sticky_err), .err_cnt(err_cnt),
        .lap_pulse(lap_pulse), .lap_cnt(lap_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    // Behavioural model state (plain integers, lap measured in whole steps)
    bit m_locked, started;
    int hp, hu, hl, hd, anc, ns, dir;
    int e_locked, e_expected, e_mis, e_sticky, e_err, e_lap, e_lapcnt, e_cmp;

    always @(posedge clk) begin
        int pred;
        if (reset) begin
            m_locked = 0; hp = 0; hu = 0; hl = 0; hd = 0; anc = 0; ns = 0; dir = 0;
            e_locked = 0; e_expected = 0; e_mis = 0; e_sticky = 0; e_err = 0;
            e_lap = 0; e_lapcnt = 0; e_cmp = 0;
        end else begin
            pred = hl ? hd : (hp + (hu ? 3 : 5)) % 8;
            e_expected = pred; e_mis = 0; e_lap = 0; e_cmp = 0;
            if (en) begin
                if (m_locked) begin
                    e_cmp = 1;
                    e_mis = (int'(count) != pred);
                    if (e_mis || hl != 0 || hu != dir) begin
                        anc = count; ns = 0; dir = up;
                    end else begin
                        ns++;
                        if (ns == 8) begin
                            if (int'(count) == anc) begin
                                e_lap = 1; e_lapcnt = (e_lapcnt + 1) % 256; ns = 0;
                            end else begin
                                anc = count; ns = 0; dir = up;
                            end
                        end
                    end
                end else begin
                    anc = count; ns = 0; dir = up; m_locked = 1;
                end
                hp = count; hu = up; hl = load; hd = data;
            end else begin
                m_locked = 0;
            end
            if (e_mis) begin
                e_sticky = 1;
                e_err = clr_err ? 1 : (e_err < 255 ? e_err + 1 : 255);
            end else if (clr_err) begin
                e_sticky = 0; e_err = 0;
            end
            e_locked = m_locked;
        end
        started = 1;
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (started) begin
            chk("locked", locked, e_locked);
            chk("mismatch", mismatch, e_mis);
            chk("sticky_err", sticky_err, e_sticky);
            chk("err_cnt", err_cnt, e_err);
            chk("lap_pulse", lap_pulse, e_lap);
            chk("lap_cnt", lap_cnt, e_lapcnt);
            chk("mismatch_and_lap", int'(mismatch && lap_pulse), 0);
            if (e_cmp != 0) chk("expected", expected, e_expected);
        end
    end

    logic [2:0] cnt;  // stand-in for the counter being monitored

    task automatic cyc(input logic e, input logic u, input logic l, input logic [2:0] d,
                       input logic c, input int f);
        en = e; up = u; load = l; data = d; clr_err = c;
        count = (f >= 0) ? 3'(f) : cnt;
        @(posedge clk); #2;
        if (l) cnt = d;
        else if (u) cnt = count + 3'd3;
        else cnt = count - 3'd3;
    endtask

    task automatic rst();
        reset = 1'b1; count = cnt;
        @(posedge clk); #2;
        reset = 1'b0; cnt = 3'd0;
    endtask

    initial begin
        int le, ll;
        logic cur_up;
        reset = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; data = 3'd0; clr_err = 1'b0;
        cnt = 3'd0; count = 3'd0;
        rst();
        chk("reset_err", err_cnt, 0);
        chk("reset_locked", locked, 0);

        // Up lap 0,3,6,1,4,7,2,5,0
        cyc(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, -1);
        chk("lock_after_1", locked, 1);
        for (int i = 1; i < 9; i++) cyc(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, -1);
        chk("up_lap_pulse", lap_pulse, 1);
        chk("up_lap_cnt", lap_cnt, 1);
        chk("model_up_lap", e_lapcnt, 1);

        // Down lap, then direction toggle restarts step counting
        rst();
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, -1);
        chk("down_lap_cnt", lap_cnt, 1);
        chk("down_err", err_cnt, 0);
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, -1);
        chk("toggle_no_lap", lap_cnt, 1);
        cyc(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, -1);
        chk("toggle_lap_pulse", lap_pulse, 1);
        chk("toggle_lap_cnt", lap_cnt, 2);

        // Load 6 at count 4, anchor moves to 6
        rst();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, -1);
        cyc(1'b1, 1'b1, 1'b1, 3'd6, 1'b0, -1);
        cyc(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, -1);
        chk("load_no_mismatch", mismatch, 0);
        chk("load_expected", expected, 6);
        cyc(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, -1);
        chk("after_load_expected", expected, 1);
        chk("after_load_mismatch", mismatch, 0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, -1);
        chk("load_no_lap_yet", lap_cnt, 0);
        cyc(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, -1);
        chk("load_anchor_lap", lap_cnt, 1);

        // Single fault: 4 where 3 was due
        rst();
        cyc(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, -1);
        cyc(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 4);
        chk("fault_mismatch", mismatch, 1);
        chk("fault_expected", expected, 3);
        chk("fault_err", err_cnt, 1);
        chk("fault_sticky", sticky_err, 1);
        cyc(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, -1);
        chk("resync_mismatch", mismatch, 0);
        chk("resync_err", err_cnt, 1);

        // Saturation and clear
        for (int i = 0; i < 300; i++) cyc(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, int'(cnt + 3'd1));
        chk("sat_err", err_cnt, 255);
        chk("model_sat_err", e_err, 255);
        cyc(1'b1, 1'b1, 1'b0, 3'd0, 1'b1, -1);
        chk("clr_err", err_cnt, 0);
        chk("clr_sticky", sticky_err, 0);
        cyc(1'b1, 1'b1, 1'b0, 3'd0, 1'b1, int'(cnt + 3'd2));
        chk("clr_vs_mismatch_err", err_cnt, 1);
        chk("clr_vs_mismatch_sticky", sticky_err, 1);

        // Enable gap of two cycles
        cyc(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, -1);
        le = e_err; ll = e_lapcnt;
        cyc(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, -1);
        chk("gap_unlocked", locked, 0);
        cyc(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, -1);
        chk("gap_err_hold", err_cnt, le);
        chk("gap_lap_hold", lap_cnt, ll);
        cyc(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, -1);
        chk("relock", locked, 1);
        cyc(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, -1);
        chk("relock_no_mismatch", mismatch, 0);

        // Randomized traffic
        cur_up = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 1) begin
                rst();
            end else begin
                if ($urandom_range(0, 99) < 4) cur_up = ~cur_up;
                cyc($urandom_range(0, 19) != 0, cur_up,
                    $urandom_range(0, 99) < 4, 3'($urandom_range(0, 7)),
                    $urandom_range(0, 99) < 3,
                    ($urandom_range(0, 99) < 4) ? int'(cnt + 3'($urandom_range(1, 7))) : -1);
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
